// File: rtl/vram_pkg.sv
// Shared geometry, timing constants and write-FSM encoding for the text-mode VRAM controller.
package vram_pkg;

  localparam int ADDR_W     = 11;
  localparam int DATA_W     = 8;
  localparam int COLS       = 80;
  localparam int ROWS       = 25;
  localparam int CELLS      = COLS * ROWS;
  localparam int RD_LATENCY = 2;
  localparam int COL_W      = 7;
  localparam int ROW_W      = 5;
  localparam int PIPE_DEPTH = 1 + RD_LATENCY;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } wr_state_e;

endpackage

// File: rtl/vram_ctrl_if.sv
// Host byte-write channel into the VRAM controller (valid/ready handshake).
interface vram_ctrl_if;
  import vram_pkg::*;

  logic              host_valid;
  logic              host_ready;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_data;

  modport master (
    output host_valid,
    output host_addr,
    output host_data,
    input  host_ready
  );

  modport slave (
    input  host_valid,
    input  host_addr,
    input  host_data,
    output host_ready
  );

endinterface

// File: rtl/vram_fetch_pipe.sv
// Carries request valid and cell tags alongside the RAM read so they emerge with read_data.
module vram_fetch_pipe
  import vram_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [COL_W-1:0] in_col,
  input  logic [ROW_W-1:0] in_row,
  output logic             out_valid,
  output logic [COL_W-1:0] out_col,
  output logic [ROW_W-1:0] out_row
);

  logic [PIPE_DEPTH-1:0]            valid_q, valid_d;
  logic [PIPE_DEPTH-1:0][COL_W-1:0] col_q, col_d;
  logic [PIPE_DEPTH-1:0][ROW_W-1:0] row_q, row_d;

  always_comb begin
    valid_d = {valid_q[PIPE_DEPTH-2:0], in_valid};
    col_d   = {col_q[PIPE_DEPTH-2:0], in_col};
    row_d   = {row_q[PIPE_DEPTH-2:0], in_row};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      valid_q <= valid_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  assign out_valid = valid_q[PIPE_DEPTH-1];
  assign out_col   = col_q[PIPE_DEPTH-1];
  assign out_row   = row_q[PIPE_DEPTH-1];

endmodule

// File: rtl/vram_ctrl.sv
// Text VRAM controller: arbitrates host writes against the fill engine and
// sequences scanout reads with scroll-base wrap and latency-aligned cell tags.
module vram_ctrl
  import vram_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  vram_ctrl_if.slave        host,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_data,
  output logic              fill_busy,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] scroll_base,
  input  logic              char_req,
  output logic              char_valid,
  output logic [DATA_W-1:0] char_data,
  output logic [COL_W-1:0]  char_col,
  output logic [ROW_W-1:0]  char_row,
  output logic              write_ce,
  output logic [ADDR_W-1:0] write_ad,
  output logic [DATA_W-1:0] write_data,
  output logic [ADDR_W-1:0] read_ad,
  input  logic [DATA_W-1:0] read_data
);

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);

  // ---------------- write side ----------------
  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [DATA_W-1:0] fill_byte_q, fill_byte_d;
  logic              write_ce_q, write_ce_d;
  logic [ADDR_W-1:0] write_ad_q, write_ad_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              host_ready_q, host_ready_d;
  logic              fill_busy_q, fill_busy_d;

  always_comb begin
    state_d      = state_q;
    fill_cnt_d   = fill_cnt_q;
    fill_byte_d  = fill_byte_q;
    write_ce_d   = 1'b0;
    write_ad_d   = write_ad_q;
    write_data_d = write_data_q;
    case (state_q)
      IDLE: begin
        // The host write and a same-cycle fill_start both proceed; the fill
        // only issues its first write one cycle later, so they never collide.
        if (host.host_valid) begin
          write_ce_d   = 1'b1;
          write_ad_d   = host.host_addr;
          write_data_d = host.host_data;
        end
        if (fill_start) begin
          state_d     = FILL;
          fill_cnt_d  = '0;
          fill_byte_d = fill_data;
        end
      end
      FILL: begin
        write_ce_d   = 1'b1;
        write_ad_d   = fill_cnt_q;
        write_data_d = fill_byte_q;
        fill_cnt_d   = fill_cnt_q + ADDR_W'(1);
        if (fill_cnt_q == LAST_CELL) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    host_ready_d = (state_d == IDLE);
    fill_busy_d  = (state_d == FILL);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      fill_cnt_q   <= '0;
      fill_byte_q  <= '0;
      write_ce_q   <= 1'b0;
      write_ad_q   <= '0;
      write_data_q <= '0;
      host_ready_q <= 1'b0;
      fill_busy_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_cnt_q   <= fill_cnt_d;
      fill_byte_q  <= fill_byte_d;
      write_ce_q   <= write_ce_d;
      write_ad_q   <= write_ad_d;
      write_data_q <= write_data_d;
      host_ready_q <= host_ready_d;
      fill_busy_q  <= fill_busy_d;
    end
  end

  assign write_ce        = write_ce_q;
  assign write_ad        = write_ad_q;
  assign write_data      = write_data_q;
  assign host.host_ready = host_ready_q;
  assign fill_busy       = fill_busy_q;

  // ---------------- scan side ----------------
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] lin_q, lin_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] read_ad_q, read_ad_d;
  logic [ADDR_W-1:0] fetch_base, fetch_lin;
  logic [COL_W-1:0]  fetch_col;
  logic [ROW_W-1:0]  fetch_row;

  always_comb begin
    base_d     = base_q;
    lin_d      = lin_q;
    col_d      = col_q;
    row_d      = row_q;
    read_ad_d  = read_ad_q;
    fetch_base = base_q;
    fetch_lin  = lin_q;
    fetch_col  = col_q;
    fetch_row  = row_q;
    // frame_start rewinds before a same-cycle request is served
    if (frame_start) begin
      base_d     = scroll_base;
      fetch_base = scroll_base;
      fetch_lin  = '0;
      fetch_col  = '0;
      fetch_row  = '0;
      lin_d      = '0;
      col_d      = '0;
      row_d      = '0;
    end
    if (char_req) begin
      read_ad_d = fetch_base + fetch_lin;
      if (fetch_lin == LAST_CELL) begin
        lin_d = '0;
        col_d = '0;
        row_d = '0;
      end else begin
        lin_d = fetch_lin + ADDR_W'(1);
        if (fetch_col == LAST_COL) begin
          col_d = '0;
          row_d = fetch_row + ROW_W'(1);
        end else begin
          col_d = fetch_col + COL_W'(1);
          row_d = fetch_row;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      base_q    <= '0;
      lin_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      read_ad_q <= '0;
    end else begin
      base_q    <= base_d;
      lin_q     <= lin_d;
      col_q     <= col_d;
      row_q     <= row_d;
      read_ad_q <= read_ad_d;
    end
  end

  assign read_ad = read_ad_q;

  // ---------------- fetch return ----------------
  logic             pipe_valid;
  logic [COL_W-1:0] pipe_col;
  logic [ROW_W-1:0] pipe_row;

  vram_fetch_pipe u_fetch_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (char_req),
    .in_col    (fetch_col),
    .in_row    (fetch_row),
    .out_valid (pipe_valid),
    .out_col   (pipe_col),
    .out_row   (pipe_row)
  );

  logic [DATA_W-1:0] data_hold_q, data_hold_d;
  logic [COL_W-1:0]  col_hold_q, col_hold_d;
  logic [ROW_W-1:0]  row_hold_q, row_hold_d;

  // read_data arrives in the valid cycle itself, so it is passed through and
  // captured to hold the outputs steady between fetches.
  always_comb begin
    data_hold_d = data_hold_q;
    col_hold_d  = col_hold_q;
    row_hold_d  = row_hold_q;
    if (pipe_valid) begin
      data_hold_d = read_data;
      col_hold_d  = pipe_col;
      row_hold_d  = pipe_row;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_hold_q <= '0;
      col_hold_q  <= '0;
      row_hold_q  <= '0;
    end else begin
      data_hold_q <= data_hold_d;
      col_hold_q  <= col_hold_d;
      row_hold_q  <= row_hold_d;
    end
  end

  assign char_valid = pipe_valid;
  assign char_data  = pipe_valid ? read_data : data_hold_q;
  assign char_col   = pipe_valid ? pipe_col  : col_hold_q;
  assign char_row   = pipe_valid ? pipe_row  : row_hold_q;

endmodule

// File: tb/tb_vram_ctrl.sv
// Self-checking bench for vram_ctrl with a behavioural 2-cycle-latency RAM and
// a cell-level reference model of writes and scanout.
module tb_vram_ctrl;
  import vram_pkg::*;

  logic              clk;
  logic              reset;
  logic              fill_start;
  logic [DATA_W-1:0] fill_data;
  logic              fill_busy;
  logic              frame_start;
  logic [ADDR_W-1:0] scroll_base;
  logic              char_req;
  logic              char_valid;
  logic [DATA_W-1:0] char_data;
  logic [COL_W-1:0]  char_col;
  logic [ROW_W-1:0]  char_row;
  logic              write_ce;
  logic [ADDR_W-1:0] write_ad;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] read_ad;
  logic [DATA_W-1:0] read_data;

  vram_ctrl_if hif ();

  vram_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .host        (hif.slave),
    .fill_start  (fill_start),
    .fill_data   (fill_data),
    .fill_busy   (fill_busy),
    .frame_start (frame_start),
    .scroll_base (scroll_base),
    .char_req    (char_req),
    .char_valid  (char_valid),
    .char_data   (char_data),
    .char_col    (char_col),
    .char_row    (char_row),
    .write_ce    (write_ce),
    .write_ad    (write_ad),
    .write_data  (write_data),
    .read_ad     (read_ad),
    .read_data   (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM stand-in: address sampled one edge, data registered the next.
  logic [DATA_W-1:0] ram [2**ADDR_W];
  logic [ADDR_W-1:0] ram_ra;
  always @(posedge clk) begin
    if (write_ce) ram[write_ad] <= write_data;
    ram_ra    <= read_ad;
    read_data <= ram[ram_ra];
  end

  int checks;
  int failures;
  int cyc;

  logic [DATA_W-1:0] ref_mem [2**ADDR_W];

  typedef struct {
    int due;
    int addr;
    int col;
    int row;
  } exp_t;
  exp_t exp_q[$];
  int   m_base;
  int   m_lin;
  int   last_data, last_col, last_row;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Model: describe the next cell to fetch and advance the cursor.
  function automatic exp_t model_fetch();
    exp_t e;
    e.due  = cyc + 1 + RD_LATENCY;
    e.addr = (m_base + m_lin) % (2**ADDR_W);
    e.col  = m_lin % COLS;
    e.row  = m_lin / COLS;
    m_lin  = (m_lin + 1) % CELLS;
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    checks++;
    if ({write_ce, fill_busy, char_valid, hif.host_ready} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got ce=%b busy=%b cv=%b rdy=%b want all 0",
               write_ce, fill_busy, char_valid, hif.host_ready);
    end
    checks++;
    if (read_ad !== '0 || write_ad !== '0 || char_data !== '0) begin
      failures++;
      $display("FAIL reset_buses: got read_ad=%h write_ad=%h char_data=%h want 0",
               read_ad, write_ad, char_data);
    end
    reset = 1'b1;
    step();
    checks++;
    if (hif.host_ready !== 1'b1 || write_ce !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got rdy=%b ce=%b want rdy=1 ce=0", hif.host_ready, write_ce);
    end
    m_base = 0; m_lin = 0; exp_q.delete();
    last_data = 0; last_col = 0; last_row = 0;
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_host_write();
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    for (int i = 0; i < 52; i++) begin
      if (i == 0) begin a = 11'h123; d = 8'hA5; end
      else if (i <= 48) begin a = ADDR_W'(CELLS + i - 1); d = DATA_W'($urandom); end
      else begin a = ADDR_W'($urandom_range(0, 2**ADDR_W - 1)); d = DATA_W'($urandom); end
      hif.host_valid = 1'b1; hif.host_addr = a; hif.host_data = d;
      step();
      hif.host_valid = 1'b0;
      ref_mem[a] = d;
      checks++;
      if (write_ce !== 1'b1 || write_ad !== a || write_data !== d || hif.host_ready !== 1'b1) begin
        failures++;
        $display("FAIL host_write: got ce=%b ad=%h data=%h rdy=%b want ce=1 ad=%h data=%h rdy=1",
                 write_ce, write_ad, write_data, hif.host_ready, a, d);
      end
      if (i % 4 == 0) begin
        step();
        checks++;
        if (write_ce !== 1'b0) begin
          failures++;
          $display("FAIL host_idle: got ce=%b want 0", write_ce);
        end
      end
    end
    $display("test_host_write done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_fill(input logic [DATA_W-1:0] fd);
    logic [ADDR_W-1:0] ha;
    logic [DATA_W-1:0] hd;
    int bad_wr, bad_flag;
    ha = ADDR_W'($urandom_range(0, 2**ADDR_W - 1));
    hd = DATA_W'($urandom);
    fill_data = fd; fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    checks++;
    if (fill_busy !== 1'b1 || hif.host_ready !== 1'b0 || write_ce !== 1'b0) begin
      failures++;
      $display("FAIL fill_enter: got busy=%b rdy=%b ce=%b want 1 0 0", fill_busy, hif.host_ready, write_ce);
    end
    hif.host_valid = 1'b1; hif.host_addr = ha; hif.host_data = hd;
    bad_wr = 0; bad_flag = 0;
    for (int k = 0; k < CELLS; k++) begin
      if (k == 700) begin fill_start = 1'b1; fill_data = ~fd; end
      else fill_start = 1'b0;
      step();
      ref_mem[k] = fd;
      checks++;
      if (write_ce !== 1'b1 || write_ad !== ADDR_W'(k) || write_data !== fd) begin
        failures++;
        if (bad_wr++ < 5)
          $display("FAIL fill_write: got ce=%b ad=%h data=%h want ce=1 ad=%h data=%h",
                   write_ce, write_ad, write_data, k, fd);
      end
      checks++;
      if (fill_busy !== (k < CELLS - 1) || hif.host_ready !== (k == CELLS - 1)) begin
        failures++;
        if (bad_flag++ < 5)
          $display("FAIL fill_flags: k=%0d got busy=%b rdy=%b want busy=%b rdy=%b",
                   k, fill_busy, hif.host_ready, (k < CELLS - 1), (k == CELLS - 1));
      end
    end
    fill_start = 1'b0;
    step();
    hif.host_valid = 1'b0;
    ref_mem[ha] = hd;
    checks++;
    if (write_ce !== 1'b1 || write_ad !== ha || write_data !== hd || fill_busy !== 1'b0) begin
      failures++;
      $display("FAIL fill_held_host: got ce=%b ad=%h data=%h busy=%b want ce=1 ad=%h data=%h busy=0",
               write_ce, write_ad, write_data, fill_busy, ha, hd);
    end
    step();
    checks++;
    if (write_ce !== 1'b0) begin
      failures++;
      $display("FAIL fill_done_idle: got ce=%b want 0", write_ce);
    end
    $display("test_fill data=%h done checks=%0d failures=%0d", fd, checks, failures);
  endtask

  task automatic test_same_cycle(input logic [DATA_W-1:0] fd);
    int bad_wr;
    fill_data = fd; fill_start = 1'b1;
    hif.host_valid = 1'b1; hif.host_addr = 11'h7FF; hif.host_data = 8'h55;
    step();
    fill_start = 1'b0; hif.host_valid = 1'b0;
    ref_mem[11'h7FF] = 8'h55;
    checks++;
    if (write_ce !== 1'b1 || write_ad !== 11'h7FF || write_data !== 8'h55 || fill_busy !== 1'b1) begin
      failures++;
      $display("FAIL same_cycle_host: got ce=%b ad=%h data=%h busy=%b want ce=1 ad=7ff data=55 busy=1",
               write_ce, write_ad, write_data, fill_busy);
    end
    bad_wr = 0;
    for (int k = 0; k < CELLS; k++) begin
      step();
      ref_mem[k] = fd;
      checks++;
      if (write_ce !== 1'b1 || write_ad !== ADDR_W'(k) || write_data !== fd) begin
        failures++;
        if (bad_wr++ < 5)
          $display("FAIL same_cycle_fill: got ce=%b ad=%h data=%h want ce=1 ad=%h data=%h",
                   write_ce, write_ad, write_data, k, fd);
      end
    end
    step();
    checks++;
    if (write_ce !== 1'b0 || hif.host_ready !== 1'b1) begin
      failures++;
      $display("FAIL same_cycle_end: got ce=%b rdy=%b want ce=0 rdy=1", write_ce, hif.host_ready);
    end
    $display("test_same_cycle done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_scan_wrap();
    exp_t e;
    exp_t r;
    int   exp_ra;
    logic req;
    int   bad;
    bad = 0;
    for (int t = 0; t < CELLS + 1 || exp_q.size() > 0; t++) begin
      if (t > CELLS + 20) break;
      req = (t < CELLS + 1);
      frame_start = (t == 0); scroll_base = 11'h7F0; char_req = req;
      if (t == 0) begin m_base = 'h7F0; m_lin = 0; end
      if (req) begin e = model_fetch(); exp_q.push_back(e); exp_ra = e.addr; end
      step();
      frame_start = 1'b0; char_req = 1'b0;
      if (req) begin
        checks++;
        if (read_ad !== ADDR_W'(exp_ra)) begin
          failures++;
          if (bad++ < 8) $display("FAIL scan_read_ad: t=%0d got %h want %h", t, read_ad, exp_ra);
        end
      end
      checks++;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        r = exp_q.pop_front();
        if (char_valid !== 1'b1 || char_data !== ref_mem[r.addr] ||
            char_col !== COL_W'(r.col) || char_row !== ROW_W'(r.row)) begin
          failures++;
          if (bad++ < 8)
            $display("FAIL scan_char: got v=%b d=%h c=%0d r=%0d want v=1 d=%h c=%0d r=%0d",
                     char_valid, char_data, char_col, char_row, ref_mem[r.addr], r.col, r.row);
        end
        last_data = ref_mem[r.addr]; last_col = r.col; last_row = r.row;
      end else if (char_valid !== 1'b0) begin
        failures++;
        if (bad++ < 8) $display("FAIL scan_idle_valid: got v=%b want 0", char_valid);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scan_drain: got %0d outstanding want 0", exp_q.size());
      exp_q.delete();
    end
    $display("test_scan_wrap done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_fetch_pattern();
    exp_t e;
    exp_t r;
    int   exp_ra;
    logic req, fs;
    logic [ADDR_W-1:0] nb;
    int   bad;
    bad = 0;
    for (int t = 0; t < 700 || exp_q.size() > 0; t++) begin
      if (t > 720) break;
      if (t < 200)      req = (t % 2 == 0);
      else if (t < 400) req = 1'b1;
      else if (t < 700) req = 1'($urandom_range(0, 1));
      else              req = 1'b0;
      fs = (t == 0) || (t > 400 && t < 700 && $urandom_range(0, 49) == 0);
      nb = ADDR_W'($urandom);
      frame_start = fs; scroll_base = nb; char_req = req;
      if (fs) begin m_base = nb; m_lin = 0; end
      if (req) begin e = model_fetch(); exp_q.push_back(e); exp_ra = e.addr; end
      step();
      frame_start = 1'b0; char_req = 1'b0;
      if (req) begin
        checks++;
        if (read_ad !== ADDR_W'(exp_ra)) begin
          failures++;
          if (bad++ < 8) $display("FAIL fetch_read_ad: t=%0d got %h want %h", t, read_ad, exp_ra);
        end
      end
      checks++;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        r = exp_q.pop_front();
        if (char_valid !== 1'b1 || char_data !== ref_mem[r.addr] ||
            char_col !== COL_W'(r.col) || char_row !== ROW_W'(r.row)) begin
          failures++;
          if (bad++ < 8)
            $display("FAIL fetch_char: got v=%b d=%h c=%0d r=%0d want v=1 d=%h c=%0d r=%0d",
                     char_valid, char_data, char_col, char_row, ref_mem[r.addr], r.col, r.row);
        end
        last_data = ref_mem[r.addr]; last_col = r.col; last_row = r.row;
      end else if (char_valid !== 1'b0 || char_data !== DATA_W'(last_data) ||
                   char_col !== COL_W'(last_col) || char_row !== ROW_W'(last_row)) begin
        failures++;
        if (bad++ < 8)
          $display("FAIL fetch_hold: got v=%b d=%h c=%0d r=%0d want v=0 d=%h c=%0d r=%0d",
                   char_valid, char_data, char_col, char_row, last_data, last_col, last_row);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL fetch_drain: got %0d outstanding want 0", exp_q.size());
      exp_q.delete();
    end
    $display("test_fetch_pattern done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] fd;
    fd = DATA_W'($urandom);
    fill_data = fd; fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    repeat (498) step();
    char_req = 1'b1;
    step();
    step();
    char_req = 1'b0;
    for (int k = 0; k < 500; k++) ref_mem[k] = fd;
    checks++;
    if (write_ce !== 1'b1 || write_ad !== 11'd499 || write_data !== fd || fill_busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_fill_progress: got ce=%b ad=%0d data=%h busy=%b want ce=1 ad=499 data=%h busy=1",
               write_ce, write_ad, write_data, fill_busy, fd);
    end
    reset = 1'b0;
    step();
    checks++;
    if (write_ce !== 1'b0 || fill_busy !== 1'b0 || char_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got ce=%b busy=%b cv=%b want 0 0 0", write_ce, fill_busy, char_valid);
    end
    reset = 1'b1;
    step();
    checks++;
    if (hif.host_ready !== 1'b1 || write_ce !== 1'b0 || char_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_release: got rdy=%b ce=%b cv=%b want 1 0 0", hif.host_ready, write_ce, char_valid);
    end
    char_req = 1'b1;
    step();
    checks++;
    if (read_ad !== 11'd0) begin
      failures++;
      $display("FAIL mid_first_fetch: got read_ad=%h want 000", read_ad);
    end
    step();
    char_req = 1'b0;
    checks++;
    if (read_ad !== 11'd1) begin
      failures++;
      $display("FAIL mid_second_fetch: got read_ad=%h want 001", read_ad);
    end
    step();
    checks++;
    if (char_valid !== 1'b1 || char_data !== fd || char_col !== 7'd0 || char_row !== 5'd0) begin
      failures++;
      $display("FAIL mid_first_char: got v=%b d=%h c=%0d r=%0d want v=1 d=%h c=0 r=0",
               char_valid, char_data, char_col, char_row, fd);
    end
    step();
    checks++;
    if (char_valid !== 1'b1 || char_data !== fd || char_col !== 7'd1 || char_row !== 5'd0) begin
      failures++;
      $display("FAIL mid_second_char: got v=%b d=%h c=%0d r=%0d want v=1 d=%h c=1 r=0",
               char_valid, char_data, char_col, char_row, fd);
    end
    $display("test_reset_mid done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    reset = 1'b0;
    fill_start = 1'b0; fill_data = '0;
    frame_start = 1'b0; scroll_base = '0; char_req = 1'b0;
    hif.host_valid = 1'b0; hif.host_addr = '0; hif.host_data = '0;
    test_reset();
    test_host_write();
    test_fill(8'h20);
    test_same_cycle(DATA_W'($urandom));
    test_scan_wrap();
    test_fetch_pattern();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
